// File: rtl/multi_dac_driver.sv
// Multi-lane DAC sample driver.
// Three output sources share one registered output stage:
//   - LUT mode: every lane looks up its own replicated LUT (2-cycle latency)
//   - static mode: a GPIO-loaded word is driven continuously
//   - burst mode: the static word is driven for burst_len cycles per del_trig rising edge
// Configuration arrives over a byte-wide GPIO port strobed by the rising edge of w_clk.
//
// Burst FSM states
//   state   | meaning
//   S_IDLE  | not in burst mode, outputs follow the other modes
//   S_ARMED | burst mode selected, waiting for a del_trig rising edge
//   S_RUN   | driving the latched static word, counting down the latched burst length
module multi_dac_driver #(
    parameter int NUM_SAMP   = 16,
    parameter int SAMP_W     = 16,
    parameter int LUT_AW     = 10,
    parameter int A_LUT_ADDR = 0,
    parameter int A_LUT_DATA = 1,
    parameter int A_STATIC   = 2,
    parameter int A_MODE     = 3,
    parameter int A_BURST    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  gpio_in,
    input  logic [NUM_SAMP*SAMP_W-1:0]   fsm_val_in,
    input  logic                         fsm_in_valid,
    input  logic                         del_trig,
    output logic [NUM_SAMP*SAMP_W-1:0]   dac_out,
    output logic                         dac_valid,
    output logic                         burst_busy
);

    localparam int DW    = NUM_SAMP * SAMP_W;
    localparam int NBYTE = 2 * NUM_SAMP;
    localparam int BPW   = $clog2(NBYTE);
    localparam int DEPTH = 2 ** LUT_AW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    // GPIO capture and configuration registers
    logic [23:0]        r_gpio_q;
    logic               r_wclk_s;
    logic               r_wclk_p;
    logic               r_tog_addr;
    logic               r_tog_data;
    logic               r_tog_burst;
    logic [7:0]         r_lo_addr;
    logic [7:0]         r_lo_data;
    logic [7:0]         r_lo_burst;
    logic [LUT_AW-1:0]  r_lut_ptr;
    logic [BPW-1:0]     r_sptr;
    logic [DW-1:0]      r_static;
    logic [1:0]         r_mode;
    logic [15:0]        r_blen;

    // Burst FSM
    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic [15:0]        r_cnt;
    logic [DW-1:0]      r_bword;
    logic               r_trig_d;
    logic               w_trig_rise;

    // LUT datapath
    logic               r_vld1;
    logic [DW-1:0]      w_rd_bus;
    logic               w_lut_we;
    logic [SAMP_W-1:0]  w_lut_wdata;

    logic               w_wr;
    logic [15:0]        w_addr;
    logic [7:0]         w_data;
    logic               w_wr_addr;
    logic               w_wr_data;
    logic               w_wr_static;
    logic               w_wr_mode;
    logic               w_wr_burst;

    // Upper GPIO bits and the low (non-index) sample bits carry no function here.
    logic               w_unused;
    assign w_unused = ^{gpio_in[31:25], fsm_val_in};

    assign w_wr        = r_wclk_s & ~r_wclk_p;
    assign w_addr      = r_gpio_q[15:0];
    assign w_data      = r_gpio_q[23:16];
    assign w_wr_addr   = w_wr && (w_addr == 16'(A_LUT_ADDR));
    assign w_wr_data   = w_wr && (w_addr == 16'(A_LUT_DATA));
    assign w_wr_static = w_wr && (w_addr == 16'(A_STATIC));
    assign w_wr_mode   = w_wr && (w_addr == 16'(A_MODE));
    assign w_wr_burst  = w_wr && (w_addr == 16'(A_BURST));
    assign w_lut_we    = w_wr_data & r_tog_data;
    assign w_lut_wdata = SAMP_W'({w_data, r_lo_data});
    assign w_trig_rise = del_trig & ~r_trig_d;

    // GPIO edge detect and register-file writes.
    // Both w_clk history bits reset high so a w_clk held high through reset
    // release is not mistaken for a rising edge; a 0 must be sampled first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gpio_q    <= '0;
            r_wclk_s    <= 1'b1;
            r_wclk_p    <= 1'b1;
            r_tog_addr  <= 1'b0;
            r_tog_data  <= 1'b0;
            r_tog_burst <= 1'b0;
            r_lo_addr   <= '0;
            r_lo_data   <= '0;
            r_lo_burst  <= '0;
            r_lut_ptr   <= '0;
            r_sptr      <= '0;
            r_static    <= '0;
            r_mode      <= '0;
            r_blen      <= '0;
        end else begin
            r_gpio_q <= gpio_in[23:0];
            r_wclk_s <= gpio_in[24];
            r_wclk_p <= r_wclk_s;
            if (w_wr_addr) begin
                r_sptr <= '0;
                if (!r_tog_addr) begin
                    r_lo_addr  <= w_data;
                    r_tog_addr <= 1'b1;
                end else begin
                    r_lut_ptr  <= LUT_AW'({w_data, r_lo_addr});
                    r_tog_addr <= 1'b0;
                end
            end
            if (w_wr_data) begin
                if (!r_tog_data) begin
                    r_lo_data  <= w_data;
                    r_tog_data <= 1'b1;
                end else begin
                    r_lut_ptr  <= r_lut_ptr + LUT_AW'(1);
                    r_tog_data <= 1'b0;
                end
            end
            if (w_wr_static) begin
                r_static[{r_sptr, 3'b000} +: 8] <= w_data;
                r_sptr <= (r_sptr == BPW'(NBYTE - 1)) ? '0 : r_sptr + BPW'(1);
            end
            if (w_wr_mode) begin
                r_mode <= w_data[1:0];
            end
            if (w_wr_burst) begin
                if (!r_tog_burst) begin
                    r_lo_burst  <= w_data;
                    r_tog_burst <= 1'b1;
                end else begin
                    r_blen      <= {w_data, r_lo_burst};
                    r_tog_burst <= 1'b0;
                end
            end
        end
    end

    // Replicated LUTs: one per lane so every lane gets its own read port.
    for (genvar g = 0; g < NUM_SAMP; g++) begin : g_lut
        logic [SAMP_W-1:0] r_mem [DEPTH];
        logic [SAMP_W-1:0] r_rd;
        logic [LUT_AW-1:0] w_idx;

        assign w_idx = fsm_val_in[g*SAMP_W + SAMP_W - 1 -: LUT_AW];

        // LUT contents survive reset
        always_ff @(posedge clk) begin
            if (w_lut_we) begin
                r_mem[r_lut_ptr] <= w_lut_wdata;
            end
        end

        // First pipeline stage: registered lookup
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_rd <= '0;
            end else begin
                r_rd <= r_mem[w_idx];
            end
        end

        assign w_rd_bus[g*SAMP_W +: SAMP_W] = r_rd;
    end

    // Burst FSM state, down-counter and trigger-time snapshot of the static word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bword  <= '0;
            r_trig_d <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_trig_d <= del_trig;
            if (w_load) begin
                r_cnt   <= r_blen;
                r_bword <= r_static;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - 16'd1;
            end
        end
    end

    // Burst FSM next state; RUN ends on terminal count 1 so it lasts r_blen cycles
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_mode == 2'd2) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (r_mode != 2'd2) begin
                    w_state_nxt = S_IDLE;
                end else if (w_trig_rise && (r_blen != 16'd0)) begin
                    w_state_nxt = S_RUN;
                    w_load      = 1'b1;
                end
            end
            S_RUN: begin
                if (r_mode != 2'd2) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 16'd1) begin
                    w_state_nxt = S_ARMED;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output stage. Burst outputs are decoded from the next state so the first
    // RUN cycle appears directly after the sampled trigger edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld1     <= 1'b0;
            dac_out    <= '0;
            dac_valid  <= 1'b0;
            burst_busy <= 1'b0;
        end else begin
            r_vld1     <= fsm_in_valid;
            burst_busy <= (w_state_nxt == S_RUN);
            case (r_mode)
                2'd0: begin
                    dac_out   <= r_vld1 ? w_rd_bus : '0;
                    dac_valid <= r_vld1;
                end
                2'd1: begin
                    dac_out   <= r_static;
                    dac_valid <= 1'b1;
                end
                2'd2: begin
                    if (w_state_nxt == S_RUN) begin
                        dac_out   <= w_load ? r_static : r_bword;
                        dac_valid <= 1'b1;
                    end else begin
                        dac_out   <= '0;
                        dac_valid <= 1'b0;
                    end
                end
                default: begin
                    dac_out   <= '0;
                    dac_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_dac_driver.sv
// Directed bench for multi_dac_driver with a queue-based scoreboard.
module tb_multi_dac_driver;

    localparam int NS = 16;
    localparam int SW = 16;
    localparam int DW = NS * SW;
    localparam logic [15:0] A_LUT_ADDR = 16'd0;
    localparam logic [15:0] A_LUT_DATA = 16'd1;
    localparam logic [15:0] A_STATIC   = 16'd2;
    localparam logic [15:0] A_MODE     = 16'd3;
    localparam logic [15:0] A_BURST    = 16'd4;

    typedef logic [DW+1:0] exp_t;   // {burst_busy, dac_valid, dac_out}

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   gpio_in = '0;
    logic [DW-1:0] fsm_val_in = '0;
    logic          fsm_in_valid = 1'b0;
    logic          del_trig = 1'b0;
    logic [DW-1:0] dac_out;
    logic          dac_valid;
    logic          burst_busy;

    int            checks = 0;
    int            failures = 0;
    exp_t          sb[$];
    logic [15:0]   m_lut [1024];
    logic [DW-1:0] w_static;
    exp_t          e_run;

    multi_dac_driver dut (
        .clk          (clk),
        .rst          (rst),
        .gpio_in      (gpio_in),
        .fsm_val_in   (fsm_val_in),
        .fsm_in_valid (fsm_in_valid),
        .del_trig     (del_trig),
        .dac_out      (dac_out),
        .dac_valid    (dac_valid),
        .burst_busy   (burst_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input exp_t exp);
        exp_t obs;
        obs = {burst_busy, dac_valid, dac_out};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            chk(tag, sb.pop_front());
        end
    endtask

    task automatic gpio_wr(input logic [15:0] a, input logic [7:0] d);
        gpio_in = {7'd0, 1'b0, d, a};
        step();
        gpio_in[24] = 1'b1;
        step();
        step();
        gpio_in[24] = 1'b0;
        step();
    endtask

    // One valid cycle with a different LUT index per lane, then one invalid cycle.
    task automatic lane_run(input string tag);
        exp_t e;
        int   ix;
        e = '0;
        for (int i = 0; i < NS; i++) begin
            ix = (i == NS - 1) ? 1023 : i * 5;
            fsm_val_in[i*SW +: SW] = 16'(ix << 6) | 16'h002A;
            e[i*SW +: SW] = m_lut[ix];
        end
        e[DW] = 1'b1;
        fsm_in_valid = 1'b1;
        sb.push_back(e);
        step();
        fsm_in_valid = 1'b0;
        fsm_val_in = ~fsm_val_in;
        sb.push_back('0);
        step();
        pop_chk(tag);
        step();
        pop_chk({tag, "_gap"});
    endtask

    initial begin
        w_static = {{8{16'hFFFF}}, {8{16'h0000}}};
        e_run = {1'b1, 1'b1, w_static};

        // Reset state
        step();
        step();
        chk("reset_state", '0);
        rst = 1'b1;
        step();

        // LUT load: address 0, then entry j = -j
        gpio_wr(A_LUT_ADDR, 8'h00);
        gpio_wr(A_LUT_ADDR, 8'h00);
        for (int j = 0; j < 1024; j++) begin
            m_lut[j] = 16'(-j);
            gpio_wr(A_LUT_DATA, m_lut[j][7:0]);
            gpio_wr(A_LUT_DATA, m_lut[j][15:8]);
        end
        gpio_wr(A_MODE, 8'd0);

        // Full index sweep, 2-cycle latency
        for (int j = 0; j <= 1024; j++) begin
            if (j < 1024) begin
                fsm_val_in = {NS{16'(j << 6)}};
                fsm_in_valid = 1'b1;
                sb.push_back({1'b0, 1'b1, {NS{m_lut[j]}}});
            end else begin
                fsm_val_in = '0;
                fsm_in_valid = 1'b0;
                sb.push_back('0);
            end
            step();
            if (sb.size() == 2) pop_chk("lut_sweep");
        end
        step();
        pop_chk("lut_tail");

        // Pointer wrapped to 0: the 1025th write lands on entry 0
        gpio_wr(A_LUT_DATA, 8'hCD);
        gpio_wr(A_LUT_DATA, 8'hAB);
        m_lut[0] = 16'hABCD;
        lane_run("lut_wrap");

        // Static word: lanes 8..15 all ones
        for (int k = 0; k < 2 * NS; k++) begin
            gpio_wr(A_STATIC, (k >= NS) ? 8'hFF : 8'h00);
        end
        gpio_wr(A_MODE, 8'd1);
        for (int c = 0; c < 100; c++) begin
            sb.push_back({1'b0, 1'b1, w_static});
            pop_chk("static_hold");
            step();
        end

        // Burst of 5 with a second edge inside RUN
        gpio_wr(A_BURST, 8'd5);
        gpio_wr(A_BURST, 8'd0);
        gpio_wr(A_MODE, 8'd2);
        for (int c = 0; c < 2; c++) begin
            sb.push_back('0);
            pop_chk("armed_idle");
            step();
        end
        del_trig = 1'b1;
        for (int s = 1; s <= 20; s++) begin
            step();
            sb.push_back((s <= 5) ? e_run : exp_t'(0));
            pop_chk("burst5");
            if (s == 2) del_trig = 1'b0;
            if (s == 3) del_trig = 1'b1;
        end

        // burst_len = 0: trigger produces nothing
        gpio_wr(A_BURST, 8'd0);
        gpio_wr(A_BURST, 8'd0);
        del_trig = 1'b0;
        step();
        del_trig = 1'b1;
        for (int s = 0; s < 8; s++) begin
            step();
            sb.push_back('0);
            pop_chk("burst_len0");
        end

        // Abort: mode 2 -> 3 during RUN cycle 2
        gpio_wr(A_BURST, 8'd8);
        gpio_wr(A_BURST, 8'd0);
        del_trig = 1'b0;
        gpio_in = {7'd0, 1'b0, 8'd3, A_MODE};
        step();
        del_trig = 1'b1;
        gpio_in[24] = 1'b1;
        step();
        chk("abort_run_c1", e_run);
        step();
        chk("abort_run_c2", e_run);
        step();
        chk("abort_drop", '0);
        gpio_in[24] = 1'b0;
        del_trig = 1'b0;
        step();
        del_trig = 1'b1;
        step();
        chk("mode3_zero", '0);

        // Reset mid-op: pending LUT data low byte and a running burst
        gpio_wr(A_LUT_ADDR, 8'd5);
        gpio_wr(A_LUT_ADDR, 8'd0);
        gpio_wr(A_LUT_DATA, 8'h11);
        gpio_wr(A_MODE, 8'd2);
        del_trig = 1'b0;
        step();
        del_trig = 1'b1;
        step();
        chk("pre_reset_run", e_run);
        rst = 1'b0;
        #1;
        chk("reset_async", '0);
        gpio_in = {7'd0, 1'b1, 8'h77, A_LUT_DATA};
        step();
        step();
        rst = 1'b1;
        step();
        step();
        step();
        chk("post_reset_idle", '0);
        gpio_in[24] = 1'b0;
        step();
        gpio_wr(A_LUT_ADDR, 8'd5);
        gpio_wr(A_LUT_ADDR, 8'd0);
        gpio_wr(A_LUT_DATA, 8'h34);
        gpio_wr(A_LUT_DATA, 8'h12);
        m_lut[5] = 16'h1234;
        lane_run("post_reset_lut");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
